fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, bubble word; sll $0,$0,0, decodes as harmless R-type.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction-memory request, registered.
REQ-006 SHALL have port imem_addr  output  32  request byte address, registered, word aligned.
REQ-007 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle for the outstanding request.
REQ-008 SHALL have port imem_rdata  input  32  returned instruction word.
REQ-009 SHALL have port id_stall  input  1  decode cannot accept a new instruction this cycle.
REQ-010 SHALL have port branch_taken  input  1  redirect to branch_target.
REQ-011 SHALL have port branch_target  input  32  branch destination.
REQ-012 SHALL have port jump  input  1  redirect to jump_target.
REQ-013 SHALL have port jump_target  input  32  jump destination.
REQ-014 SHALL have port if_id_instr  output  32  IF/ID instruction register.
REQ-015 SHALL have port if_id_pc4  output  32  IF/ID PC+4 register.
REQ-016 SHALL have port if_id_valid  output  1  IF/ID holds a real instruction.
REQ-017 SHALL have port op  output  6  if_id_instr[31:26], combinational, drives the control unit opcode input.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT (one request outstanding), HOLD (fetched word buffered, decode stalled).
REQ-019 SHALL allow at most one outstanding request; imem_req and imem_addr SHALL be stable from issue until imem_ack.
REQ-020 SHALL in IDLE issue a request at pc on the next edge and go to WAIT.
REQ-021 "Accept" SHALL mean id_stall==0 or if_id_valid==0.
REQ-022 SHALL on imem_ack in WAIT with accept and no kill: load if_id_instr=imem_rdata, if_id_pc4=imem_addr+4, if_id_valid=1, pc=imem_addr+4, and issue the next request at pc+4 on the same edge (no bubble cycle).
REQ-023 SHALL on imem_ack in WAIT without accept: capture word and address into the skid buffer, drop imem_req, go to HOLD.
REQ-024 SHALL in HOLD, on the first cycle with accept, move the buffer into IF/ID, set pc=buffered address+4, issue the next request, go to WAIT.
REQ-025 SHALL hold IF/ID unchanged whenever id_stall==1 and if_id_valid==1 and no redirect is active.
REQ-026 SHALL treat jump as priority over branch_taken when both are high; the selected target SHALL become the new pc.
REQ-027 SHALL on redirect: load IF/ID with NOP_INSTR and if_id_valid=0 regardless of id_stall, discard the skid buffer (HOLD->WAIT, request at target).
REQ-028 SHALL, on redirect while WAIT without imem_ack, set a kill flag; the next returned word SHALL be dropped, the flag cleared, and a request issued at the redirected pc.
REQ-029 SHALL, on redirect coinciding with imem_ack, drop the returned word and issue the request at the target on the same edge.
REQ-030 SHALL compute pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-031 SHALL ignore imem_ack outside WAIT.

Reset
REQ-032 SHALL on rst_n==0 asynchronously set pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc4=0, if_id_valid=0, kill=0, skid buffer empty.
REQ-033 SHALL, when reset asserts mid-request, abandon the request; a late imem_ack after release SHALL be ignored (state IDLE).

Structure
REQ-034 SHALL place the FSM state encoding, NOP_INSTR and RESET_PC default in shared package fetch_pkg.
REQ-035 SHALL implement the one-entry word+address buffer as sub-module fetch_skid_buf.

Verification
REQ-036 Reset release, imem_ack one cycle after each req, rdata 32'h8C01_0004 -> imem_addr 0,4,8 back-to-back; if_id_instr=32'h8C01_0004, op=6'b100011, if_id_pc4=4.
REQ-037 id_stall=1 for 3 cycles while ack arrives for addr 8 -> HOLD, imem_req=0, IF/ID unchanged; after release IF/ID=word@8, next req addr 12.
REQ-038 branch_taken=1, branch_target=32'h40 with request outstanding, ack 2 cycles later -> word dropped, if_id_valid=0, op=0, next req addr 32'h40.
REQ-039 jump=1 (target 32'h100) and branch_taken=1 (target 32'h40) same cycle coincident with imem_ack -> word dropped, next req addr 32'h100.
REQ-040 pc=32'hFFFF_FFFC accepted fetch -> if_id_pc4=0, next req addr 0.
REQ-041 rst_n low mid-WAIT, ack arriving after release -> ack ignored, outputs at reset values, first req at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the FSM encoding, the IF/ID bundle and the PC increment helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pcPlus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry word+address buffer used while decode is stalled.
// Clear has priority so a redirect always discards the entry.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] wordIn,
  input  logic [31:0] addrIn,
  output logic        full,
  output logic [31:0] word,
  output logic [31:0] addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      word <= '0;
      addr <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      word <= wordIn;
      addr <= addrIn;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with single outstanding request,
// skid buffer for decode stalls and redirect kill handling.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  op
);

  fetchState_e stateQ, stateD;
  if_id_t      ifIdQ, ifIdD;
  logic [31:0] pcQ, pcD;
  logic [31:0] addrQ, addrD;
  logic        reqQ, reqD;
  logic        killQ, killD;

  logic        skidFull;
  logic [31:0] skidWord, skidAddr;

  logic        redirect, accept, ackWait;
  logic [31:0] target;
  logic        idleIssue, deliver, skidLoad;
  logic        drain, killDrop;

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_target
                         : branch_target;
  assign accept   = !id_stall || !ifIdQ.valid;
  assign ackWait  = (stateQ == WAIT) && imem_ack;

  assign idleIssue = (stateQ == IDLE) && !redirect;
  assign deliver   = ackWait && !killQ
                   && !redirect && accept;
  assign skidLoad  = ackWait && !killQ
                   && !redirect && !accept;
  assign killDrop  = ackWait && killQ && !redirect;
  assign drain     = (stateQ == HOLD) && skidFull
                   && !redirect && accept;

  fetch_skid_buf uSkid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skidLoad),
    .clear  (redirect || drain),
    .wordIn (imem_rdata),
    .addrIn (addrQ),
    .full   (skidFull),
    .word   (skidWord),
    .addr   (skidAddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: stateD = WAIT;
      WAIT: if (skidLoad) stateD = HOLD;
      HOLD: if (redirect || drain) stateD = WAIT;
      default: stateD = IDLE;
    endcase
  end

  // A consumed IF/ID entry turns into a bubble unless refilled.
  always_comb begin
    pcD   = pcQ;
    addrD = addrQ;
    reqD  = reqQ;
    killD = killQ;
    ifIdD = ifIdQ;
    if (accept)
      ifIdD = '{instr: NOP_INSTR,
                pc4:   ifIdQ.pc4,
                valid: 1'b0};
    unique case (1'b1)
      redirect: begin
        pcD   = target;
        ifIdD = '{instr: NOP_INSTR,
                  pc4:   ifIdQ.pc4,
                  valid: 1'b0};
        if ((stateQ == WAIT) && !imem_ack) begin
          killD = 1'b1;
        end else begin
          killD = 1'b0;
          reqD  = 1'b1;
          addrD = target;
        end
      end
      idleIssue: begin
        reqD  = 1'b1;
        addrD = pcQ;
      end
      deliver: begin
        ifIdD = '{instr: imem_rdata,
                  pc4:   pcPlus4(addrQ),
                  valid: 1'b1};
        pcD   = pcPlus4(addrQ);
        addrD = pcPlus4(addrQ);
      end
      skidLoad: reqD = 1'b0;
      drain: begin
        ifIdD = '{instr: skidWord,
                  pc4:   pcPlus4(skidAddr),
                  valid: 1'b1};
        pcD   = pcPlus4(skidAddr);
        reqD  = 1'b1;
        addrD = pcPlus4(skidAddr);
      end
      killDrop: begin
        killD = 1'b0;
        addrD = pcQ;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcQ   <= RESET_PC;
      addrQ <= RESET_PC;
      reqQ  <= 1'b0;
      killQ <= 1'b0;
      ifIdQ <= '{instr: NOP_INSTR,
                 pc4:   32'h0,
                 valid: 1'b0};
    end else begin
      pcQ   <= pcD;
      addrQ <= addrD;
      reqQ  <= reqD;
      killQ <= killD;
      ifIdQ <= ifIdD;
    end
  end

  assign imem_req    = reqQ;
  assign imem_addr   = addrQ;
  assign if_id_instr = ifIdQ.instr;
  assign if_id_pc4   = ifIdQ.pc4;
  assign if_id_valid = ifIdQ.valid;
  assign op          = ifIdQ.instr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: transaction model plus
// directed scenarios with literal expectations.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        id_stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return 32'h8C01_0004 + a;
  endfunction

  assign imem_rdata = wordAt(imem_addr);

  fetch_stage #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_stall(id_stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .op(op)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a started flag, one outstanding request, a pending
  // kill, a one-slot holding buffer and the IF/ID contents.
  bit          mStarted, mOut, mKill, mHeld;
  logic [31:0] mPc, mAddr, mHeldWord, mHeldAddr;
  logic [31:0] mInstr, mPc4;
  bit          mValid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mStarted = 0; mOut = 0; mKill = 0; mHeld = 0;
      mPc = RPC; mAddr = RPC;
      mInstr = NOP; mPc4 = 0; mValid = 0;
    end else begin
      bit takeIt;
      bit redir;
      logic [31:0] tgt;
      takeIt = !id_stall || !mValid;
      redir  = jump || branch_taken;
      tgt    = jump ? jump_target : branch_target;
      if (takeIt) begin mInstr = NOP; mValid = 0; end
      if (redir) begin
        mInstr = NOP; mValid = 0; mHeld = 0;
        mPc = tgt; mStarted = 1;
        if (mOut && !imem_ack) mKill = 1;
        else begin mKill = 0; mOut = 1; mAddr = tgt; end
      end else if (!mStarted) begin
        mStarted = 1; mOut = 1; mAddr = mPc;
      end else if (mOut && imem_ack) begin
        if (mKill) begin
          mKill = 0; mAddr = mPc;
        end else if (takeIt) begin
          mInstr = wordAt(mAddr); mPc4 = mAddr + 4; mValid = 1;
          mPc = mAddr + 4; mAddr = mAddr + 4;
        end else begin
          mHeld = 1; mHeldWord = wordAt(mAddr); mHeldAddr = mAddr;
          mOut = 0;
        end
      end else if (mHeld && takeIt) begin
        mInstr = mHeldWord; mPc4 = mHeldAddr + 4; mValid = 1;
        mPc = mHeldAddr + 4; mHeld = 0;
        mOut = 1; mAddr = mHeldAddr + 4;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("m_req",   {31'b0, imem_req},    {31'b0, mOut});
    chk("m_addr",  imem_addr,            mAddr);
    chk("m_instr", if_id_instr,          mInstr);
    chk("m_pc4",   if_id_pc4,            mPc4);
    chk("m_valid", {31'b0, if_id_valid}, {31'b0, mValid});
    chk("m_op",    {26'b0, op},          {26'b0, mInstr[31:26]});
  end

  task automatic cyc(input bit ack, input bit stall,
                     input bit br, input logic [31:0] bt,
                     input bit j, input logic [31:0] jt);
    @(negedge clk);
    imem_ack = ack; id_stall = stall;
    branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt;
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    #3;
    chk("rst_req",   {31'b0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, RPC);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
    chk("rst_pc4",   if_id_pc4, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #3;
    chk("issue0_req",  {31'b0, imem_req}, 32'd1);
    chk("issue0_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("f0_instr", if_id_instr, 32'h8C01_0004);
    chk("f0_op",    {26'b0, op}, {26'b0, 6'b100011});
    chk("f0_pc4",   if_id_pc4, 32'd4);
    chk("f0_addr",  imem_addr, 32'd4);
    cyc(1, 0, 0, 0, 0, 0);
    chk("f1_addr",  imem_addr, 32'd8);
    // stall while the word at 8 returns
    cyc(1, 1, 0, 0, 0, 0);
    chk("hold_req",   {31'b0, imem_req}, 32'd0);
    chk("hold_instr", if_id_instr, 32'h8C01_0008);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    chk("hold_pc4", if_id_pc4, 32'd8);
    chk("hold_req2", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("drain_instr", if_id_instr, 32'h8C01_000C);
    chk("drain_pc4",   if_id_pc4, 32'd12);
    chk("drain_addr",  imem_addr, 32'd12);
    // branch while request outstanding, late ack
    cyc(0, 0, 1, 32'h40, 0, 0);
    chk("kill_valid", {31'b0, if_id_valid}, 32'd0);
    chk("kill_op",    {26'b0, op}, 32'd0);
    chk("kill_addr",  imem_addr, 32'd12);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("kill_next", imem_addr, 32'h40);
    chk("kill_val2", {31'b0, if_id_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("tgt_instr", if_id_instr, 32'h8C01_0044);
    // jump beats branch, coincident with ack
    cyc(1, 0, 1, 32'h40, 1, 32'h100);
    chk("jb_addr",  imem_addr, 32'h100);
    chk("jb_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("jb_instr", if_id_instr, 32'h8C01_0104);
    // pc wrap
    cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_req", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0);
    chk("wrap_pc4",   if_id_pc4, 32'd0);
    chk("wrap_addr",  imem_addr, 32'd0);
    chk("wrap_instr", if_id_instr, 32'h8C01_0000);
    // redirect while buffered, decode still stalled
    cyc(1, 1, 0, 0, 0, 0);
    chk("hb_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 1, 1, 32'h200, 0, 0);
    chk("hb_valid", {31'b0, if_id_valid}, 32'd0);
    chk("hb_addr",  imem_addr, 32'h200);
    cyc(1, 1, 0, 0, 0, 0);
    chk("hb_instr", if_id_instr, 32'h8C01_0204);
    chk("hb_pc4",   if_id_pc4, 32'h204);
    for (int i = 0; i < 24; i++)
      cyc(i % 3 != 2, (i % 5 == 1) || (i % 5 == 2),
          i == 10, 32'h80, i == 17, 32'h300);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    // reset mid-request, late ack after release
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_req",   {31'b0, imem_req}, 32'd0);
    chk("mr_addr",  imem_addr, RPC);
    chk("mr_instr", if_id_instr, NOP);
    chk("mr_valid", {31'b0, if_id_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b1;
    @(posedge clk); #3;
    chk("late_req",   {31'b0, imem_req}, 32'd1);
    chk("late_addr",  imem_addr, RPC);
    chk("late_valid", {31'b0, if_id_valid}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("late_instr", if_id_instr, 32'h8C01_0004);
    cyc(0, 0, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
